// File: rtl/nn_pkg.sv
// Shared helpers and default widths for the NN datapath stages.
package nn_pkg;

    localparam int NN_ACC_BW = 16;
    localparam int NN_OUT_BW = 8;

    typedef struct packed {
        logic signed [63:0] lo;
        logic signed [63:0] hi;
    } sat_range_t;

    function automatic int max_w(input int a, input int b);
        if (a > b) begin
            return a;
        end else begin
            return b;
        end
    endfunction

    // Representable output range: unsigned after ReLU, two's complement otherwise.
    function automatic sat_range_t sat_range(input int out_bw, input bit relu);
        sat_range_t r;
        if (relu) begin
            r.lo = 64'sd0;
            r.hi = (64'sd1 <<< out_bw) - 64'sd1;
        end else begin
            r.lo = -(64'sd1 <<< (out_bw - 1));
            r.hi = (64'sd1 <<< (out_bw - 1)) - 64'sd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/round_shift_sat.sv
// Two-cycle ReLU + round-half-up arithmetic right shift + saturation to OUT_BW.
module round_shift_sat
    import nn_pkg::*;
#(
    parameter int IN_BW    = 17,
    parameter int OUT_BW   = NN_OUT_BW,
    parameter int SHIFT_BW = 4,
    parameter int RELU     = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                vld_in,
    input  logic [IN_BW-1:0]    data_in,
    input  logic [SHIFT_BW-1:0] shift,
    output logic [OUT_BW-1:0]   data_out,
    output logic                vld_out
);

    localparam int X_BW = IN_BW + 1;
    localparam sat_range_t RANGE = sat_range(OUT_BW, RELU != 0);
    localparam logic signed [63:0] SAT_LO = RANGE.lo;
    localparam logic signed [63:0] SAT_HI = RANGE.hi;
    localparam logic [SHIFT_BW-1:0] SH_ONE = {{(SHIFT_BW-1){1'b0}}, 1'b1};
    localparam logic [X_BW-1:0] X_ONE = {{(X_BW-1){1'b0}}, 1'b1};

    logic signed [X_BW-1:0] rnd_s;
    logic signed [X_BW-1:0] x_s;
    logic signed [X_BW-1:0] s2_r;
    logic                   v2_r;
    logic signed [63:0]     s2_wide_s;
    logic [OUT_BW-1:0]      sat_s;

    // ReLU clamp and half-LSB rounding offset ahead of the shift.
    always_comb begin
        rnd_s = {X_BW{1'b0}};
        x_s   = {X_BW{1'b0}};
        if (shift != {SHIFT_BW{1'b0}}) begin
            rnd_s = X_ONE << (shift - SH_ONE);
        end else begin
            rnd_s = {X_BW{1'b0}};
        end
        if ((RELU != 0) && data_in[IN_BW-1]) begin
            x_s = {X_BW{1'b0}};
        end else begin
            x_s = $signed({data_in[IN_BW-1], data_in}) + rnd_s;
        end
    end

    // Stage 2: arithmetic shift; oversized shifts floor to 0 or -1.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_r <= {X_BW{1'b0}};
            v2_r <= 1'b0;
        end else begin
            s2_r <= x_s >>> shift;
            v2_r <= vld_in;
        end
    end

    // Clamp the shifted value into the output range.
    always_comb begin
        s2_wide_s = $signed({{(64-X_BW){s2_r[X_BW-1]}}, s2_r});
        sat_s     = {OUT_BW{1'b0}};
        if (s2_wide_s > SAT_HI) begin
            sat_s = SAT_HI[OUT_BW-1:0];
        end else if (s2_wide_s < SAT_LO) begin
            sat_s = SAT_LO[OUT_BW-1:0];
        end else begin
            sat_s = s2_wide_s[OUT_BW-1:0];
        end
    end

    // Stage 3: output register holds its value between pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out <= {OUT_BW{1'b0}};
            vld_out  <= 1'b0;
        end else begin
            vld_out <= v2_r;
            if (v2_r) begin
                data_out <= sat_s;
            end else begin
                data_out <= data_out;
            end
        end
    end

endmodule

// File: rtl/acc_requant_stage.sv
// Captures completed adder-tree sums, adds bias and requantizes to activation width.
module acc_requant_stage
    import nn_pkg::*;
#(
    parameter int LOG2_NO_IN = 1,
    parameter int ACC_BW     = NN_ACC_BW,
    parameter int BIAS_BW    = 16,
    parameter int SHIFT_BW   = 4,
    parameter int OUT_BW     = NN_OUT_BW,
    parameter int RELU       = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                new_sum,
    input  logic [ACC_BW-1:0]   acc_in,
    input  logic [BIAS_BW-1:0]  bias,
    input  logic [SHIFT_BW-1:0] shift,
    output logic [OUT_BW-1:0]   data_out,
    output logic                vld_out
);

    localparam int S1_W = max_w(ACC_BW, BIAS_BW) + 1;

    logic                ns_last_s;
    logic                primed_r;
    logic                capture_s;
    logic [S1_W-1:0]     acc_ext_s;
    logic [S1_W-1:0]     bias_ext_s;
    logic [S1_W-1:0]     s1_r;
    logic [SHIFT_BW-1:0] sh1_r;
    logic                v1_r;

    generate
        if (LOG2_NO_IN > 0) begin : g_dly
            logic [LOG2_NO_IN-1:0] ns_d_r;

            // Mirror the accumulator's pipeline depth on the new_sum strobe.
            always_ff @(posedge clk) begin
                if (rst) begin
                    ns_d_r <= {LOG2_NO_IN{1'b0}};
                end else begin
                    ns_d_r[0] <= new_sum;
                    for (int k = 1; k < LOG2_NO_IN; k++) begin
                        ns_d_r[k] <= ns_d_r[k-1];
                    end
                end
            end

            assign ns_last_s = ns_d_r[LOG2_NO_IN-1];
        end else begin : g_nodly
            assign ns_last_s = new_sum;
        end
    endgenerate

    // The first delayed strobe after reset only opens a sum; later ones close one.
    always_ff @(posedge clk) begin
        if (rst) begin
            primed_r <= 1'b0;
        end else if (ns_last_s) begin
            primed_r <= 1'b1;
        end else begin
            primed_r <= primed_r;
        end
    end

    assign capture_s  = ns_last_s & primed_r;
    assign acc_ext_s  = {{(S1_W-ACC_BW){acc_in[ACC_BW-1]}}, acc_in};
    assign bias_ext_s = {{(S1_W-BIAS_BW){bias[BIAS_BW-1]}}, bias};

    // Stage 1: bias add at one guard bit above the wider operand.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_r  <= {S1_W{1'b0}};
            sh1_r <= {SHIFT_BW{1'b0}};
            v1_r  <= 1'b0;
        end else begin
            v1_r <= capture_s;
            if (capture_s) begin
                s1_r  <= acc_ext_s + bias_ext_s;
                sh1_r <= shift;
            end else begin
                s1_r  <= s1_r;
                sh1_r <= sh1_r;
            end
        end
    end

    round_shift_sat #(
        .IN_BW   (S1_W),
        .OUT_BW  (OUT_BW),
        .SHIFT_BW(SHIFT_BW),
        .RELU    (RELU)
    ) u_rss (
        .clk     (clk),
        .rst     (rst),
        .vld_in  (v1_r),
        .data_in (s1_r),
        .shift   (sh1_r),
        .data_out(data_out),
        .vld_out (vld_out)
    );

endmodule

// File: tb/tb_acc_requant_stage.sv
// Directed bench driving a ReLU and a signed instance of acc_requant_stage in lockstep.
module tb_acc_requant_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        new_sum;
    logic [15:0] acc_in;
    logic [15:0] bias;
    logic [3:0]  shift;
    logic [7:0]  dout_r;
    logic        vld_r;
    logic [7:0]  dout_s;
    logic        vld_s;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    acc_requant_stage #(
        .LOG2_NO_IN(1), .ACC_BW(16), .BIAS_BW(16), .SHIFT_BW(4), .OUT_BW(8), .RELU(1)
    ) u_relu (
        .clk(clk), .rst(rst), .new_sum(new_sum), .acc_in(acc_in), .bias(bias),
        .shift(shift), .data_out(dout_r), .vld_out(vld_r)
    );

    acc_requant_stage #(
        .LOG2_NO_IN(1), .ACC_BW(16), .BIAS_BW(16), .SHIFT_BW(4), .OUT_BW(8), .RELU(0)
    ) u_sgn (
        .clk(clk), .rst(rst), .new_sum(new_sum), .acc_in(acc_in), .bias(bias),
        .shift(shift), .data_out(dout_s), .vld_out(vld_s)
    );

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Apply inputs for one cycle; returns #1 after the edge that samples them.
    task automatic drive(input logic ns, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] sh);
        new_sum = ns;
        acc_in  = a;
        bias    = b;
        shift   = sh;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        drive(1'b0, 16'd0, 16'd0, 4'd0);
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_vld_relu"}, 16'(vld_r), 16'd0);
        check_eq({tag, "_vld_sgn"},  16'(vld_s), 16'd0);
    endtask

    task automatic check_pulse(input string tag, input logic [7:0] er, input logic [7:0] es);
        check_eq({tag, "_vld_relu"},  16'(vld_r),  16'd1);
        check_eq({tag, "_vld_sgn"},   16'(vld_s),  16'd1);
        check_eq({tag, "_data_relu"}, 16'(dout_r), 16'(er));
        check_eq({tag, "_data_sgn"},  16'(dout_s), 16'(es));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_cycle();
        idle_cycle();
        rst = 1'b0;
    endtask

    // One strobe closing a sum; acc/bias/shift presented in the capture cycle.
    task automatic run_one(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic [3:0] sh, input logic [7:0] er, input logic [7:0] es);
        drive(1'b1, 16'd0, 16'd0, 4'd0);
        drive(1'b0, a, b, sh);
        check_idle({tag, "_c1"});
        idle_cycle();
        check_idle({tag, "_c2"});
        idle_cycle();
        check_pulse(tag, er, es);
        idle_cycle();
        check_idle({tag, "_c4"});
    endtask

    initial begin
        rst     = 1'b1;
        new_sum = 1'b0;
        acc_in  = 16'd0;
        bias    = 16'd0;
        shift   = 4'd0;
        do_reset();
        check_eq("rst_data_relu", 16'(dout_r), 16'd0);
        check_eq("rst_data_sgn",  16'(dout_s), 16'd0);
        check_idle("rst");

        // A lone strobe after reset never yields an output.
        for (int c = 0; c < 10; c++) begin
            check_idle("prime_only");
            drive((c == 0), 16'd0, 16'd0, 4'd0);
        end

        // Strobes at 0 and 4: capture in 5 (40+2, shift 1 -> 21), pulse only in 8.
        do_reset();
        for (int c = 0; c < 12; c++) begin
            check_eq("prime_vld_relu", 16'(vld_r), 16'((c == 8) ? 1 : 0));
            check_eq("prime_vld_sgn",  16'(vld_s), 16'((c == 8) ? 1 : 0));
            if (c == 8) begin
                check_eq("prime_data_relu", 16'(dout_r), 16'd21);
                check_eq("prime_data_sgn",  16'(dout_s), 16'd21);
            end
            drive((c == 0) || (c == 4),
                  (c == 5) ? 16'd40 : 16'd0,
                  (c == 5) ? 16'd2  : 16'd0,
                  (c == 5) ? 4'd1   : 4'd0);
        end

        run_one("rnd_105",   16'd100,     16'd5,       4'd2,  8'd26,  8'd26);
        run_one("rnd_5",     16'd5,       16'd0,       4'd2,  8'd1,   8'd1);
        run_one("rnd_6",     16'd6,       16'd0,       4'd2,  8'd2,   8'd2);
        run_one("neg_45",    -16'sd50,    16'd5,       4'd0,  8'd0,   8'hD3);
        run_one("sat_hi",    16'd2000,    16'd0,       4'd0,  8'd255, 8'd127);
        run_one("neg_6",     -16'sd6,     16'd0,       4'd2,  8'd0,   8'hFF);
        run_one("sat_lo",    -16'sd2000,  16'd0,       4'd0,  8'd0,   8'h80);
        run_one("bias_wide", 16'd30000,   16'd30000,   4'd8,  8'd234, 8'd127);
        run_one("big_shift", -16'sd30000, -16'sd30000, 4'd15, 8'd0,   8'hFE);

        // Strobe every cycle: four captures back to back.
        drive(1'b1, 16'd0, 16'd0, 4'd0);
        drive(1'b1, 16'd1, 16'd0, 4'd0);
        drive(1'b1, 16'd2, 16'd0, 4'd0);
        drive(1'b1, 16'd3, 16'd0, 4'd0);
        check_pulse("b2b_1", 8'd1, 8'd1);
        drive(1'b0, 16'd4, 16'd0, 4'd0);
        check_pulse("b2b_2", 8'd2, 8'd2);
        idle_cycle();
        check_pulse("b2b_3", 8'd3, 8'd3);
        idle_cycle();
        check_pulse("b2b_4", 8'd4, 8'd4);
        idle_cycle();
        check_idle("b2b_end");
        check_eq("hold_relu", 16'(dout_r), 16'd4);
        check_eq("hold_sgn",  16'(dout_s), 16'd4);

        // Reset in C+1 of a capture drops it and clears priming.
        drive(1'b1, 16'd0, 16'd0, 4'd0);
        drive(1'b0, 16'd50, 16'd0, 4'd0);
        rst = 1'b1;
        idle_cycle();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            check_idle("mid_rst");
            check_eq("mid_rst_data_relu", 16'(dout_r), 16'd0);
            check_eq("mid_rst_data_sgn",  16'(dout_s), 16'd0);
            idle_cycle();
        end
        drive(1'b1, 16'd0, 16'd0, 4'd0);
        drive(1'b0, 16'd9, 16'd0, 4'd0);
        for (int c = 0; c < 5; c++) begin
            check_idle("reprime");
            idle_cycle();
        end
        run_one("recover", 16'd7, 16'd0, 4'd0, 8'd7, 8'd7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
